// File: rtl/bus_arb4.sv
// Four-requester round-robin arbiter for the shared 64-bit operand/result bus.
// Grants are capped at HOLD_MAX beats; an idle cycle always separates two grants.
module bus_arb4 #(
   parameter int unsigned HOLD_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  req,
   input  logic [63:0] d0,
   input  logic [63:0] d1,
   input  logic [63:0] d2,
   input  logic [63:0] d3,
   input  logic        bus_ready,
   output logic [3:0]  gnt,
   output logic [1:0]  sel,
   output logic [63:0] bus_out,
   output logic        bus_valid
);

   localparam int unsigned CW = $clog2(HOLD_MAX + 1);
   localparam logic [CW-1:0] CntLast = CW'(HOLD_MAX - 1);

   typedef enum logic {StIdle, StGrant} state_t;

   state_t        r_state, w_state_d;
   logic [1:0]    r_ptr, w_ptr_d;
   logic [1:0]    r_sel, w_sel_d;
   logic [3:0]    r_gnt, w_gnt_d;
   logic [CW-1:0] r_cnt, w_cnt_d;
   logic [1:0]    w_pick;
   logic [1:0]    w_idx;
   logic          w_pick_ok;
   logic          w_xfer;

   // Scan from highest to lowest offset so the nearest requester to r_ptr wins.
   always_comb begin
      w_pick    = r_ptr;
      w_pick_ok = 1'b0;
      w_idx     = r_ptr;
      for (int k = 3; k >= 0; k--) begin
         w_idx = r_ptr + 2'(k);
         if (req[w_idx]) begin
            w_pick    = w_idx;
            w_pick_ok = 1'b1;
         end
      end
   end

   assign bus_valid = (r_state == StGrant) && req[r_sel];
   assign w_xfer    = bus_valid && bus_ready;

   always_comb begin
      w_state_d = r_state;
      w_ptr_d   = r_ptr;
      w_sel_d   = r_sel;
      w_gnt_d   = r_gnt;
      w_cnt_d   = r_cnt;
      unique case (r_state)
         StIdle: begin
            if (w_pick_ok) begin
               w_sel_d   = w_pick;
               w_gnt_d   = 4'b0001 << w_pick;
               w_cnt_d   = '0;
               w_state_d = StGrant;
            end
         end
         StGrant: begin
            if (!req[r_sel] || (w_xfer && (r_cnt == CntLast))) begin
               w_gnt_d   = 4'b0000;
               w_ptr_d   = r_sel + 2'd1;
               w_state_d = StIdle;
            end else if (w_xfer) begin
               w_cnt_d = r_cnt + CW'(1);
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StIdle;
         r_ptr   <= 2'd0;
         r_sel   <= 2'd0;
         r_gnt   <= 4'b0000;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_d;
         r_ptr   <= w_ptr_d;
         r_sel   <= w_sel_d;
         r_gnt   <= w_gnt_d;
         r_cnt   <= w_cnt_d;
      end
   end

   assign gnt = r_gnt;
   assign sel = r_sel;

   always_comb begin
      bus_out = d0;
      unique case (r_sel)
         2'd0: bus_out = d0;
         2'd1: bus_out = d1;
         2'd2: bus_out = d2;
         2'd3: bus_out = d3;
         default: bus_out = d0;
      endcase
   end

endmodule

// File: tb/tb_bus_arb4.sv
// Randomised scoreboard bench for bus_arb4 against a cycle-level behavioural model;
// a second instance with HOLD_MAX=1 is checked with a short directed sequence.
module tb_bus_arb4;

   localparam int HOLD = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req, req2;
   logic [63:0] d0, d1, d2, d3;
   logic        bus_ready;
   logic [3:0]  gnt, gnt2;
   logic [1:0]  sel, sel2;
   logic [63:0] bus_out, bus_out2;
   logic        bus_valid, bus_valid2;

   always #5 clk = ~clk;

   bus_arb4 #(.HOLD_MAX(HOLD)) dut (
      .clk(clk), .reset(reset), .req(req),
      .d0(d0), .d1(d1), .d2(d2), .d3(d3),
      .bus_ready(bus_ready), .gnt(gnt), .sel(sel),
      .bus_out(bus_out), .bus_valid(bus_valid)
   );

   bus_arb4 #(.HOLD_MAX(1)) dut1 (
      .clk(clk), .reset(reset), .req(req2),
      .d0(d0), .d1(d1), .d2(d2), .d3(d3),
      .bus_ready(bus_ready), .gnt(gnt2), .sel(sel2),
      .bus_out(bus_out2), .bus_valid(bus_valid2)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [63:0] exp_q[$];
   bit chk_on = 0;

   // Reference model: current owner (-1 = none), priority pointer, last owner, beats taken.
   int m_owner, m_ptr, m_sel, m_beats;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [63:0] dval(input int i);
      case (i)
         0: return d0;
         1: return d1;
         2: return d2;
         default: return d3;
      endcase
   endfunction

   task automatic step(input logic [3:0] r, input logic rdy, input logic rs);
      logic [3:0] eg;
      logic       ev;
      bit         found;
      int         c;
      @(posedge clk);
      #1;
      req = r; bus_ready = rdy; reset = rs;
      #1;
      eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      ev = (m_owner >= 0) && r[m_owner];
      check("gnt", 64'(gnt), 64'(eg));
      check("sel", 64'(sel), 64'(m_sel));
      check("bus_valid", 64'(bus_valid), 64'(ev));
      check("bus_out", bus_out, dval(m_sel));
      if (rs) begin
         m_owner = -1; m_ptr = 0; m_sel = 0; m_beats = 0;
      end else if (m_owner < 0) begin
         found = 0;
         for (int k = 0; k < 4; k++) begin
            c = (m_ptr + k) % 4;
            if (!found && r[c]) begin
               found = 1; m_owner = c; m_sel = c; m_beats = 0;
            end
         end
      end else if (!r[m_owner]) begin
         m_ptr = (m_owner + 1) % 4; m_owner = -1;
      end else if (rdy) begin
         exp_q.push_back(dval(m_owner));
         m_beats++;
         if (m_beats == HOLD) begin
            m_ptr = (m_owner + 1) % 4; m_owner = -1;
         end
      end
   endtask

   // Monitor: every accepted beat must match the next predicted beat.
   always @(negedge clk) begin
      if (chk_on && !reset && bus_valid && bus_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL beat at %0t: got %h, expected no beat", $time, bus_out);
         end else begin
            check("beat", bus_out, exp_q.pop_front());
         end
      end
   end

   initial begin
      int rp[7] = '{1, 0, 0, 1, 1, 0, 1};
      logic [3:0] h1_exp[8] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000,
                                4'b0001, 4'b0000, 4'b0010, 4'b0000};
      logic [3:0] rcur;
      reset = 1'b1; req = 4'b0; req2 = 4'b0; bus_ready = 1'b0;
      d0 = 64'hF00D; d1 = 64'hDADA; d2 = 64'hFFFF; d3 = 64'hDEAD;
      repeat (2) @(posedge clk);
      m_owner = -1; m_ptr = 0; m_sel = 0; m_beats = 0;
      chk_on = 1;

      // HOLD_MAX=1 instance: alternating single-beat grants with an idle between.
      step(4'b0000, 1'b1, 1'b0);
      req2 = 4'b0011;
      for (int i = 0; i < 8; i++) begin
         step(4'b0000, 1'b1, 1'b0);
         check("h1_gnt", 64'(gnt2), 64'(h1_exp[i]));
         check("h1_valid", 64'(bus_valid2), 64'(h1_exp[i] != 4'b0000));
         if (h1_exp[i] != 4'b0000)
            check("h1_bus_out", bus_out2, (h1_exp[i] == 4'b0001) ? 64'hF00D : 64'hDADA);
      end
      req2 = 4'b0000;

      repeat (12) step(4'b0001, 1'b1, 1'b0);
      repeat (24) step(4'b1111, 1'b1, 1'b0);
      step(4'b0000, 1'b1, 1'b0);
      step(4'b0100, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) step(4'b0100, 1'(rp[i]), 1'b0);
      repeat (4) step(4'b0100, 1'b1, 1'b0);
      repeat (2) step(4'b0000, 1'b1, 1'b0);
      repeat (3) step(4'b1000, 1'b1, 1'b0);
      step(4'b0000, 1'b1, 1'b0);
      repeat (6) step(4'b1001, 1'b1, 1'b0);
      repeat (3) step(4'b0010, 1'b0, 1'b0);
      step(4'b0010, 1'b0, 1'b1);
      repeat (4) step(4'b0010, 1'b1, 1'b0);

      rcur = 4'b0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 3) == 0) rcur = 4'($urandom);
         step(rcur, 1'($urandom), ($urandom_range(0, 99) == 0));
      end

      repeat (3) step(4'b0000, 1'b1, 1'b0);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bus_arb4.md
# bus_arb4

Four-requester round-robin arbiter for the 64-bit shared operand/result bus. It owns the select lines of an internal 64-bit 4:1 mux and grants the bus to one requester at a time. A ready/valid handshake carries beats to the single consumer. Each grant is capped at a fixed number of beats so no requester can starve the others.

## Interface
- HOLD_MAX, 4, maximum beats transferred per grant (integer, ≥1).
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request per requester; bit i = requester i.
- d0, d1, d2, d3  input  64 each  requester data; d[i] must be stable while requester i is granted and bus_valid && !bus_ready.
- bus_ready  input  1  consumer accepts current beat.
- gnt  output  4  one-hot grant, registered; 0 when no owner.
- sel  output  2  registered index of current/last owner; drives the internal mux.
- bus_out  output  64  d[sel], combinational through the 4:1 mux.
- bus_valid  output  1  beat available: state GRANT && req[sel].

## Operation
- State: state (IDLE/GRANT), ptr[1:0] (highest-priority requester), sel[1:0], cnt (width $clog2(HOLD_MAX+1)).
- IDLE:
  - If req == 0, stay.
  - Otherwise pick the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4). Load sel with it, set gnt to its one-hot, clear cnt, go to GRANT.
- GRANT:
  - A beat transfers on any cycle with bus_valid && bus_ready; cnt increments.
  - Release when either condition holds:
    - (a) req[sel] == 0 in this cycle; no transfer occurs.
    - (b) a beat transfers with cnt == HOLD_MAX-1.
  - On release: gnt ← 0, ptr ← sel+1 (2-bit wrap, 3 → 0), state ← IDLE. sel keeps its value.
  - While not released, hold state; gnt, sel stable.
- Round-robin: the just-released owner has the lowest priority at the next arbitration.
- Dead cycle: IDLE always lasts at least one cycle between grants; no back-to-back re-grant.
- Simultaneous events:
  - Requests arriving during GRANT are ignored until IDLE.
  - A non-owner req change has no effect.
  - Owner dropping req in the same cycle the cap is reached releases via (a).
- Reset (any time, including mid-grant): state IDLE, ptr 0, sel 0, gnt 0, cnt 0, bus_valid 0. bus_out = d0. An in-flight beat is discarded.

## Timing
- Grant latency: req sampled high in IDLE at edge N → gnt/sel valid after edge N, bus_valid in the same cycle (provided req is still high).
- Throughput: up to one beat per cycle while bus_ready = 1; HOLD_MAX beats in HOLD_MAX cycles.
- Release: gnt falls after the edge that sampled the release condition. The next grant appears one edge later (1 idle cycle).
- bus_out follows sel combinationally; there is no register on the data path.
- bus_valid is combinational from state, sel and req[sel]. It drops in the same cycle the owner drops req.

## Test plan
- Reset, then single request:
  - Stimulus: reset 2 cycles; d0=F00D, d1=DADA, d2=FFFF, d3=DEAD; req=0001, bus_ready=1.
  - Response: gnt=0001 one cycle after req; bus_out=F00D, bus_valid=1 for exactly 4 cycles. Then gnt=0 for 1 cycle, then gnt=0001 again.
- Round-robin fairness:
  - Stimulus: req=1111 held, bus_ready=1.
  - Response: grants cycle 0001 → 0010 → 0100 → 1000 → 0001. Each grant gives 4 beats; bus_out matches F00D, DADA, FFFF, DEAD in turn.
- Back-pressure:
  - Stimulus: req=0100, bus_ready toggling 1,0,0,1,1,0,1.
  - Response: cnt advances only on ready cycles; release after the 4th accepted beat. gnt=0100 and bus_out=FFFF hold through stalls.
- Early drop and wrap:
  - Stimulus: req=1000 granted; drop req after 2 beats; then req=1001.
  - Response: bus_valid falls immediately and gnt=0 the next cycle. Since ptr=0, requester 0 wins (gnt=0001), not 3.
- Reset mid-grant:
  - Stimulus: req=0010 granted, bus_ready=0, reset pulsed for 1 cycle.
  - Response: gnt=0000, bus_valid=0, sel=0, bus_out=F00D after the edge. Re-grant to requester 1 the cycle after reset deasserts, with cnt restarted.
- HOLD_MAX=1 variant:
  - Stimulus: req=0011.
  - Response: alternating grants 0001, idle, 0010, idle, …; one beat each.
